// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the default
// bit period, kept here so a future receiver can reuse them unchanged.
package uart_pkg;

    // Default number of clk cycles per serial bit period.
    localparam int DEFAULT_CLK_DIV = 104;

    // Data bits per frame (8N1).
    localparam int DATA_BITS = 8;

    // Width of the data-bit index (counts 0..DATA_BITS-1).
    localparam int IDX_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Width of a counter that must hold 0..clk_div-1; never narrower than one bit.
    function automatic int baud_cnt_width(input int clk_div);
        return (clk_div < 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake of the UART transmitter. The master side is
// the upstream byte source, the slave side is the transmitter itself.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 start;
    logic                 tx;
    logic                 busy;
    logic                 transmission_started;
    logic                 transmission_done;

    modport master (
        output data_in,
        output start,
        input  tx,
        input  busy,
        input  transmission_started,
        input  transmission_done
    );

    modport slave (
        input  data_in,
        input  start,
        output tx,
        output busy,
        output transmission_started,
        output transmission_done
    );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer: counts CLK_DIV clk cycles and raises tick during the last
// cycle of each period. A reload restarts the period so that the first bit of
// a frame is aligned to the cycle in which the byte was accepted.
module baud_counter
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int                 CNT_W = baud_cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Period counter: wraps at the end of every period, restarts on reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (reload || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A byte is accepted from IDLE when start is high, then
// sent as one start bit, eight data bits LSB first and one stop bit, each
// lasting CLK_DIV cycles. All outputs come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    uart_state_t          state,   state_n;
    logic [DATA_BITS-1:0] shreg,   shreg_n;
    logic [IDX_W-1:0]     idx,     idx_n;
    logic                 tx_q,    tx_n;
    logic                 busy_q,  busy_n;
    logic                 started_q, started_n;
    logic                 done_q,  done_n;
    logic                 reload;
    logic                 tick;

    baud_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .reload (reload),
        .tick   (tick)
    );

    // State and output registers; reset forces the idle line and aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            idx       <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            started_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            idx       <= idx_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            started_q <= started_n;
            done_q    <= done_n;
        end
    end

    // Next-state logic: frame sequencing, bit shifting and the two event pulses.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        idx_n     = idx;
        tx_n      = tx_q;
        busy_n    = busy_q;
        started_n = 1'b0;
        done_n    = 1'b0;
        reload    = 1'b0;

        case (state)
            ST_IDLE: begin
                // The done cycle is an IDLE cycle, so a waiting request is
                // taken here and frames end up one idle-high cycle apart.
                if (bus.start) begin
                    state_n   = ST_START;
                    shreg_n   = bus.data_in;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                    started_n = 1'b1;
                    reload    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                    tx_n    = shreg[0];
                    shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        tx_n    = shreg[0];
                        shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                        idx_n   = idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.tx                   = tx_q;
    assign bus.busy                 = busy_q;
    assign bus.transmission_started = started_q;
    assign bus.transmission_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLK_DIV=4. A frame-level reference model predicts
// every output per cycle from the accepted bytes; a line monitor decodes the
// serial output independently of the model.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int D    = 4;
    localparam int AW   = 13;
    localparam int MAXC = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_tx_if bus ();

    uart_tx #(
        .CLK_DIV (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: edge number of the last accepted byte and the byte.
    int         cyc = 0;
    int         fe  = -1;
    logic [7:0] fd  = 8'h00;

    logic [3:0] log_vec [MAXC];
    logic [3:0] exp_vec [MAXC];

    logic [7:0] rx_q[$];
    int         dist_q[$];
    int         st_cyc_q[$];
    int         dn_cyc_q[$];
    bit         mon_on  = 1'b0;
    int         mon_s   = 0;
    int         mon_off = 0;
    logic [7:0] mon_b   = 8'h00;

    // Expected {tx, busy, started, done} at offset off cycles after acceptance.
    function automatic logic [3:0] frame_expect(input int off, input logic [7:0] b);
        int   k;
        logic bitv;
        if (off < 0 || off > 10 * D) return 4'b1000;
        if (off == 10 * D) return 4'b1001;
        k = off / D;
        if (k == 0)      bitv = 1'b0;
        else if (k == 9) bitv = 1'b1;
        else             bitv = b[3'(k - 1)];
        return {bitv, 1'b1, (off == 0), 1'b0};
    endfunction

    // Model: a request is taken when the line is free, i.e. at least one cycle
    // after the previous frame's done cycle; reset drops any frame.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            fe = -1;
        end else if (bus.start && (fe < 0 || cyc >= fe + 10 * D + 1)) begin
            fe = cyc;
            fd = bus.data_in;
        end
    end

    // Record observed and predicted outputs; decode frames from the line.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            log_vec[AW'(cyc)] = {bus.tx, bus.busy, bus.transmission_started, bus.transmission_done};
            exp_vec[AW'(cyc)] = (!rst || fe < 0) ? 4'b1000 : frame_expect(cyc - fe, fd);
        end
        if (!rst) begin
            mon_on = 1'b0;
        end else begin
            if (bus.transmission_started) begin
                mon_on = 1'b1;
                mon_s  = cyc;
                mon_b  = 8'h00;
                st_cyc_q.push_back(cyc);
            end
            if (mon_on) begin
                mon_off = cyc - mon_s;
                if ((mon_off % D) == D / 2 && mon_off / D >= 1 && mon_off / D <= 8)
                    mon_b[3'(mon_off / D - 1)] = bus.tx;
            end
            if (bus.transmission_done) begin
                dn_cyc_q.push_back(cyc);
                if (mon_on) begin
                    rx_q.push_back(mon_b);
                    dist_q.push_back(cyc - mon_s);
                end
                mon_on = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until transmission_done is seen (bounded), then one more cycle
    // so the monitor has logged the frame.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus.transmission_done) begin
                seen = 1'b1;
                break;
            end
        end
        step(1);
    endtask

    task automatic test_reset();
        logic [7:0] b;
        bit         seen;
        int         n0;
        rst         = 1'b0;
        bus.start   = 1'b1;
        bus.data_in = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            step(1);
            tests++;
            if ({bus.tx, bus.busy, bus.transmission_started, bus.transmission_done} !== 4'b1000) begin
                fails++;
                $display("FAIL reset_hold: {tx,busy,started,done}=%b required 1000",
                         {bus.tx, bus.busy, bus.transmission_started, bus.transmission_done});
            end
        end
        b           = 8'($urandom);
        bus.data_in = b;
        n0          = rx_q.size();
        rst         = 1'b1;
        step(1);
        tests++;
        if (bus.transmission_started !== 1'b1 || bus.tx !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_edge: started=%b tx=%b required started=1 tx=0",
                     bus.transmission_started, bus.tx);
        end
        bus.start = 1'b0;
        wait_done(seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL reset_first_timeout: done not seen, required within 100 cycles");
        end
        tests++;
        if (rx_q.size() != n0 + 1) begin
            fails++;
            $display("FAIL reset_first_count: frames=%0d required 1", rx_q.size() - n0);
        end else if (rx_q[n0] !== b) begin
            fails++;
            $display("FAIL reset_first_data: got %h required %h", rx_q[n0], b);
        end
    endtask

    task automatic test_single_frame();
        bit seen;
        int n0;
        n0          = rx_q.size();
        bus.data_in = 8'h55;
        bus.start   = 1'b1;
        step(1);
        bus.start   = 1'b0;
        tests++;
        if (bus.transmission_started !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL single_started: started=%b busy=%b required 1 1",
                     bus.transmission_started, bus.busy);
        end
        wait_done(seen);
        tests++;
        if (!seen || rx_q.size() != n0 + 1) begin
            fails++;
            $display("FAIL single_count: seen=%0d frames=%0d required 1 frame", seen, rx_q.size() - n0);
        end else begin
            tests++;
            if (rx_q[n0] !== 8'h55) begin
                fails++;
                $display("FAIL single_data: got %h required 55", rx_q[n0]);
            end
            tests++;
            if (dist_q[n0] != 10 * D) begin
                fails++;
                $display("FAIL single_distance: got %0d required %0d", dist_q[n0], 10 * D);
            end
        end
    endtask

    task automatic test_data_stability();
        bit seen;
        int n0;
        n0          = rx_q.size();
        bus.data_in = 8'hA5;
        bus.start   = 1'b1;
        step(1);
        bus.start   = 1'b0;
        step(2);
        bus.data_in = 8'hFF;
        wait_done(seen);
        tests++;
        if (!seen || rx_q.size() != n0 + 1) begin
            fails++;
            $display("FAIL stability_count: seen=%0d frames=%0d required 1 frame", seen, rx_q.size() - n0);
        end else if (rx_q[n0] !== 8'hA5) begin
            fails++;
            $display("FAIL stability_data: got %h required a5", rx_q[n0]);
        end
    endtask

    task automatic test_back_to_back();
        int n0, s0, d0, dones;
        n0          = rx_q.size();
        s0          = st_cyc_q.size();
        d0          = dn_cyc_q.size();
        dones       = 0;
        bus.data_in = 8'h11;
        bus.start   = 1'b1;
        for (int i = 0; i < 200 && dones < 2; i++) begin
            step(1);
            if (bus.transmission_done) begin
                dones++;
                if (dones == 1) bus.data_in = 8'h22;
                else            bus.start   = 1'b0;
            end
        end
        bus.start = 1'b0;
        step(1);
        tests++;
        if (dones != 2) begin
            fails++;
            $display("FAIL b2b_timeout: done pulses=%0d required 2", dones);
        end
        tests++;
        if (st_cyc_q.size() - s0 != 2 || dn_cyc_q.size() - d0 != 2) begin
            fails++;
            $display("FAIL b2b_pulses: started=%0d done=%0d required 2 2",
                     st_cyc_q.size() - s0, dn_cyc_q.size() - d0);
        end else begin
            tests++;
            if (st_cyc_q[s0 + 1] - dn_cyc_q[d0] != 1) begin
                fails++;
                $display("FAIL b2b_gap: second start %0d cycles after first done required 1",
                         st_cyc_q[s0 + 1] - dn_cyc_q[d0]);
            end
        end
        tests++;
        if (rx_q.size() != n0 + 2) begin
            fails++;
            $display("FAIL b2b_count: frames=%0d required 2", rx_q.size() - n0);
        end else if (rx_q[n0] !== 8'h11 || rx_q[n0 + 1] !== 8'h22) begin
            fails++;
            $display("FAIL b2b_data: got %h %h required 11 22", rx_q[n0], rx_q[n0 + 1]);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] b;
        bit         seen;
        int         n0, s0;
        b           = 8'($urandom);
        n0          = rx_q.size();
        s0          = st_cyc_q.size();
        bus.data_in = b;
        bus.start   = 1'b1;
        step(1);
        bus.start   = 1'b0;
        // 17 cycles after acceptance the line carries data bit 3.
        step(17);
        bus.data_in = ~b;
        bus.start   = 1'b1;
        step(1);
        bus.start   = 1'b0;
        wait_done(seen);
        step(3);
        tests++;
        if (st_cyc_q.size() - s0 != 1 || rx_q.size() != n0 + 1) begin
            fails++;
            $display("FAIL busy_extra: started=%0d frames=%0d required 1 1",
                     st_cyc_q.size() - s0, rx_q.size() - n0);
        end else if (rx_q[n0] !== b) begin
            fails++;
            $display("FAIL busy_data: got %h required %h", rx_q[n0], b);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
            fails++;
            $display("FAIL busy_idle: busy=%b tx=%b required 0 1", bus.busy, bus.tx);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        bit         seen;
        int         n0, d0, s0;
        b           = 8'($urandom) & 8'hDF;
        bus.data_in = b;
        bus.start   = 1'b1;
        step(1);
        bus.start   = 1'b0;
        // 25 cycles after acceptance the line carries data bit 5 (forced to 0).
        step(25);
        tests++;
        if (bus.tx !== 1'b0) begin
            fails++;
            $display("FAIL midrst_bit5: tx=%b required 0", bus.tx);
        end
        d0  = dn_cyc_q.size();
        s0  = st_cyc_q.size();
        rst = 1'b0;
        #1;
        tests++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: tx=%b busy=%b required 1 0", bus.tx, bus.busy);
        end
        step(3);
        rst = 1'b1;
        step(3);
        tests++;
        if (dn_cyc_q.size() != d0 || st_cyc_q.size() != s0) begin
            fails++;
            $display("FAIL midrst_pulses: done=%0d started=%0d required 0 0",
                     dn_cyc_q.size() - d0, st_cyc_q.size() - s0);
        end
        n0          = rx_q.size();
        bus.data_in = 8'h3C;
        bus.start   = 1'b1;
        step(1);
        bus.start   = 1'b0;
        wait_done(seen);
        tests++;
        if (!seen || rx_q.size() != n0 + 1) begin
            fails++;
            $display("FAIL midrst_count: seen=%0d frames=%0d required 1 frame", seen, rx_q.size() - n0);
        end else if (rx_q[n0] !== 8'h3C || dist_q[n0] != 10 * D) begin
            fails++;
            $display("FAIL midrst_data: got %h dist %0d required 3c dist %0d",
                     rx_q[n0], dist_q[n0], 10 * D);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         seen;
        int         n0;
        for (int f = 0; f < 8; f++) begin
            b           = 8'($urandom);
            n0          = rx_q.size();
            bus.data_in = b;
            bus.start   = 1'b1;
            step($urandom_range(1, 3));
            bus.start   = 1'b0;
            wait_done(seen);
            tests++;
            if (!seen || rx_q.size() != n0 + 1) begin
                fails++;
                $display("FAIL random_count[%0d]: seen=%0d frames=%0d required 1 frame",
                         f, seen, rx_q.size() - n0);
            end else if (rx_q[n0] !== b || dist_q[n0] != 10 * D) begin
                fails++;
                $display("FAIL random_data[%0d]: got %h dist %0d required %h dist %0d",
                         f, rx_q[n0], dist_q[n0], b, 10 * D);
            end
            step($urandom_range(0, 4));
        end
    endtask

    // Cycle-by-cycle comparison of every logged output against the model.
    task automatic test_full_trace();
        int last;
        last = (cyc < MAXC) ? cyc : MAXC;
        for (int i = 1; i < last; i++) begin
            tests++;
            if (log_vec[AW'(i)] !== exp_vec[AW'(i)]) begin
                fails++;
                $display("FAIL trace cycle %0d: {tx,busy,started,done}=%b required %b",
                         i, log_vec[AW'(i)], exp_vec[AW'(i)]);
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.data_in = 8'h00;
        test_reset();
        test_single_frame();
        test_data_stability();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_random();
        test_full_trace();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 104, clk cycles per serial bit period; legal range 2..65535.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 data_in  in  8  byte to transmit, driven by the upstream byte-serialising stage.
REQ-005 start  in  1  transmit request, level-sampled each clk.
REQ-006 tx  out  1  serial line, idle high.
REQ-007 busy  out  1  high while a frame is in progress.
REQ-008 transmission_started  out  1  one-cycle pulse when a byte is accepted.
REQ-009 transmission_done  out  1  one-cycle pulse when a frame completes.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA and STOP; frame format is 8N1, LSB first.
REQ-011 In IDLE with start=1 at edge t, the block SHALL latch data_in into a shift register and enter START.
REQ-012 From t+1: tx=0, busy=1 and transmission_started=1 for exactly one cycle.
REQ-013 Each bit (start, 8 data, stop) SHALL last exactly CLK_DIV cycles, timed by a counter that reloads on every bit boundary.
REQ-014 DATA SHALL shift out bit 0 first; a 3-bit index counts 0..7 and then moves the FSM to STOP.
REQ-015 STOP SHALL drive tx=1 for CLK_DIV cycles and then return to IDLE.
REQ-016 In the first IDLE cycle after STOP, transmission_done SHALL be 1 for one cycle and busy SHALL be 0.
REQ-017 The started-to-done distance SHALL be exactly 10*CLK_DIV cycles.
REQ-018 start=1 in the same cycle as transmission_done SHALL be accepted.
  - Back-to-back frames are therefore separated by exactly one idle-high cycle.
REQ-019 start while busy=1 SHALL be ignored; requests are not queued.
REQ-020 Changes to data_in after acceptance SHALL NOT affect the frame in flight.
REQ-021 transmission_started and transmission_done SHALL never be high in the same cycle.
REQ-022 tx SHALL be a registered output, so it is glitch-free.

Reset
REQ-023 While rst=0, outputs SHALL be: tx=1, busy=0, transmission_started=0, transmission_done=0.
REQ-024 While rst=0: state=IDLE, with the bit counter, bit index and shift register at 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately.
  - tx returns high asynchronously.
  - No transmission_done pulse is produced.
REQ-026 The first edge after rst deasserts SHALL accept a start request.

Structure
REQ-027 State encodings and the default CLK_DIV SHALL live in a shared package, uart_pkg, for reuse by a later uart_rx.
REQ-028 The bit-period timer SHALL be a sub-module, baud_counter.
  - Inputs: clk, rst, reload.
  - Output: a one-cycle tick at the end of each CLK_DIV period.
  - Counter width: clog2(CLK_DIV).
REQ-029 All remaining logic (FSM, shift register, pulses) SHALL be in uart_tx.

Verification (CLK_DIV=4)
REQ-030 Reset: hold rst=0 with start=1 -> tx=1, busy=0, both pulses 0 throughout.
REQ-031 Single frame: data_in=0x55, one-cycle start pulse.
  - transmission_started on the next cycle.
  - tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - transmission_done 40 cycles after transmission_started.
REQ-032 Data stability: accept 0xA5, then set data_in=0xFF after 2 cycles -> serial data bits decode to 0xA5.
REQ-033 Back-to-back: start held at 1; data_in=0x11, then 0x22 on transmission_done.
  - Two frames, 0x11 then 0x22.
  - Exactly one idle-high cycle between frames.
  - Two started and two done pulses.
REQ-034 Busy ignore: second start pulse during data bit 3 -> no extra frame and no extra started pulse.
REQ-035 Mid-frame reset: rst=0 during data bit 5.
  - tx=1 immediately; no transmission_done pulse.
  - After release, start with 0x3C transmits 0x3C correctly.
